// File: rtl/hs_rr_arbiter.sv
// Round-robin N:1 valid/ready arbiter with burst-limited grants.
// Grant holder is registered; the granted channel's datapath is combinational.
module hs_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         VALID_UP,
  output logic [N-1:0]         READY_UP,
  input  logic [N*WIDTH-1:0]   DATA_UP,
  output logic                 VALID_DOWN,
  input  logic                 READY_DOWN,
  output logic [WIDTH-1:0]     DATA_DOWN,
  output logic [$clog2(N)-1:0] GRANT_ID,
  output logic                 BUSY
);

  localparam int IW = $clog2(N);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [IW-1:0] LAST_ID = IW'(N - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [BW-1:0] beat_q, beat_d;

  logic [IW-1:0] gnt_nxt;
  logic [IW-1:0] arb_start;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          in_grant;
  logic          xfer;
  logic          last_beat;
  logic          release_now;

  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] base,
    input int            k
  );
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  assign in_grant  = (state_q == GRANT);
  assign gnt_nxt   = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
  // A releasing holder searches from its successor, so it ranks last.
  assign arb_start = in_grant ? gnt_nxt : ptr_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (VALID_UP[wrap_add(arb_start, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(arb_start, k);
      end
    end
  end

  always_comb begin
    VALID_DOWN = 1'b0;
    READY_UP   = '0;
    DATA_DOWN  = '0;
    if (in_grant) begin
      VALID_DOWN      = VALID_UP[gnt_q];
      READY_UP[gnt_q] = READY_DOWN;
      DATA_DOWN       = DATA_UP[int'(gnt_q)*WIDTH +: WIDTH];
    end
  end

  assign xfer        = VALID_DOWN & READY_DOWN;
  assign last_beat   = xfer & (beat_q == LAST_BEAT);
  assign release_now = in_grant & (last_beat | ~VALID_UP[gnt_q]);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d  = gnt_nxt;
          beat_d = '0;
          if (pick_found) gnt_d = pick_idx;
          else state_d = IDLE;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
    end
  end

  assign BUSY     = in_grant;
  assign GRANT_ID = gnt_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Bench for hs_rr_arbiter: cycle vector table with a transfer
// scoreboard, plus a BURST=1 / N=3 rotation sequence.
module tb_hs_rr_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   valid_up;
  logic [N-1:0]   ready_up;
  logic [N*W-1:0] data_up;
  logic           valid_down;
  logic           ready_down;
  logic [W-1:0]   data_down;
  logic [1:0]     grant_id;
  logic           busy;

  logic [2:0]  b_vup;
  logic [2:0]  b_rup;
  logic [23:0] b_data;
  logic        b_vd;
  logic        b_rdy;
  logic [7:0]  b_dd;
  logic [1:0]  b_gid;
  logic        b_busy;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       rst;
    logic [3:0] vup;
    logic       rdy;
    logic       vd;
    logic [3:0] rup;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [1:0]   gid;
    logic [W-1:0] data;
  } sb_t;

  vec_t       tbl[$];
  sb_t        sb_q[$];
  sb_t        sb_e;
  int         seq[N];
  logic [6:0] b_exp[5];

  always #5 clk = ~clk;

  hs_rr_arbiter #(.WIDTH(W), .N(N), .BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .VALID_UP  (valid_up),
    .READY_UP  (ready_up),
    .DATA_UP   (data_up),
    .VALID_DOWN(valid_down),
    .READY_DOWN(ready_down),
    .DATA_DOWN (data_down),
    .GRANT_ID  (grant_id),
    .BUSY      (busy)
  );

  hs_rr_arbiter #(.WIDTH(8), .N(3), .BURST(1)) u_b1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .VALID_UP  (b_vup),
    .READY_UP  (b_rup),
    .DATA_UP   (b_data),
    .VALID_DOWN(b_vd),
    .READY_DOWN(b_rdy),
    .DATA_DOWN (b_dd),
    .GRANT_ID  (b_gid),
    .BUSY      (b_busy)
  );

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] src(input int i);
    return {8'(8'hA0 + i), 8'h5A, 16'(seq[i])};
  endfunction

  task automatic add(
    input logic       r,
    input logic [3:0] vup,
    input logic       rdy,
    input logic       vd,
    input logic [3:0] rup,
    input logic [1:0] gid,
    input logic       bsy
  );
    vec_t t;
    t.rst  = r;
    t.vup  = vup;
    t.rdy  = rdy;
    t.vd   = vd;
    t.rup  = rup;
    t.gid  = gid;
    t.busy = bsy;
    tbl.push_back(t);
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    logic [W-1:0] exp_data;
    sb_t          e;
    @(posedge clk);
    #1;
    rst_n      = t.rst;
    valid_up   = t.vup;
    ready_down = t.rdy;
    for (int i = 0; i < N; i++) data_up[i*W +: W] = src(i);
    exp_data = src(int'(t.gid));
    if (t.rst && t.vd && t.rdy) begin
      e.gid  = t.gid;
      e.data = exp_data;
      sb_q.push_back(e);
    end
    @(negedge clk);
    check($sformatf("ctl[%0d]", idx),
          64'({valid_down, ready_up, grant_id, busy}),
          64'({t.vd, t.rup, t.gid, t.busy}));
    if (t.vd)
      check($sformatf("data[%0d]", idx),
            64'(data_down), 64'(exp_data));
    for (int i = 0; i < N; i++)
      if (t.rup[i] && t.vup[i]) seq[i]++;
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_down && ready_down) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'(1), 64'(0));
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_gid", 64'(grant_id), 64'(sb_e.gid));
        check("sb_data", 64'(data_down), 64'(sb_e.data));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    valid_up   = '0;
    ready_down = 1'b0;
    data_up    = '0;
    b_vup      = '0;
    b_rdy      = 1'b0;
    b_data     = '0;
    for (int i = 0; i < N; i++) seq[i] = 0;

    // reset state
    add(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    // single requester, 6 beats, no bubble on re-grant
    add(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++)
      add(1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    // all requesters, 4 beats each
    add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 4; i++)
        add(1'b1, 4'b1111, 1'b1, 1'b1, 4'(1 << g), 2'(g), 1'b1);
    add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    // backpressure: 5 stalled cycles, then 3 beats finish the burst
    for (int i = 0; i < 5; i++)
      add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    // early release of requester 1 after 2 beats
    for (int i = 0; i < 2; i++)
      add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
    add(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
    // wrap-around from 3 back to 0
    add(1'b1, 4'b1000, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++)
      add(1'b1, 4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1);
    add(1'b1, 4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    // reset mid-burst, then fresh arbitration
    add(1'b1, 4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b1001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(1'b1, 4'b0110, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(1'b1, 4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // BURST=1, N=3: grant rotates every beat, wrapping 2 -> 0
    b_exp[0] = 7'b0_000_00_0;
    b_exp[1] = 7'b1_001_00_1;
    b_exp[2] = 7'b1_100_10_1;
    b_exp[3] = 7'b1_001_00_1;
    b_exp[4] = 7'b1_100_10_1;
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    valid_up   = '0;
    ready_down = 1'b1;
    b_vup      = 3'b101;
    b_rdy      = 1'b1;
    b_data     = {8'h12, 8'h11, 8'h10};
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("b1_ctl[%0d]", c),
            64'({b_vd, b_rup, b_gid, b_busy}), 64'(b_exp[c]));
      if (b_exp[c][6])
        check($sformatf("b1_data[%0d]", c), 64'(b_dd),
              64'(8'(8'h10 + b_exp[c][2:1])));
      @(posedge clk);
      #1;
    end

    check("sb_left", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
